// File: rtl/branch_predictor.sv
// Bimodal 2-bit-counter branch predictor: predicts in Decode, resolves in Execute.
// Define BP_GSHARE_EN to XOR a non-speculative global history register into the PHT index.
module branch_predictor #(
    parameter int         PHT_INDEX_W = 6,
    parameter logic [1:0] PHT_INIT    = 2'b01
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        branchD,
    input  logic [31:0] pcD,
    input  logic [31:0] pc_plus4D,
    input  logic [31:0] branch_targetD,
    input  logic        stallD,
    input  logic        flushE,
    input  logic        actual_takenE,
    output logic        pred_takenD,
    output logic        predict_wrong,
    output logic [31:0] correct_pcE
);

    localparam int PHT_SIZE = 1 << PHT_INDEX_W;

    logic [1:0]             pht [PHT_SIZE];
    logic [PHT_INDEX_W-1:0] idx_d;
    logic [PHT_INDEX_W-1:0] idx_e;
    logic                   valid_e;
    logic                   pred_taken_e;
    logic [31:0]            target_e;
    logic [31:0]            pc_plus4_e;
    logic [1:0]             ctr_cur;
    logic [1:0]             ctr_next;
    logic                   unused_pc_bits;

    assign unused_pc_bits = ^{pcD[31:PHT_INDEX_W+2], pcD[1:0]};

`ifdef BP_GSHARE_EN
    logic [PHT_INDEX_W-1:0] ghr;

    assign idx_d = pcD[PHT_INDEX_W+1:2] ^ ghr;

    // History only advances on resolved branches, so it never needs repair after a flush
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ghr <= '0;
        end else if (valid_e) begin
            ghr <= {ghr[PHT_INDEX_W-2:0], actual_takenE};
        end
    end
`else
    assign idx_d = pcD[PHT_INDEX_W+1:2];
`endif

    assign pred_takenD = branchD & pht[idx_d][1];

    assign predict_wrong = valid_e & (actual_takenE != pred_taken_e);
    assign correct_pcE   = actual_takenE ? target_e : pc_plus4_e;

    assign ctr_cur = pht[idx_e];

    always_comb begin
        ctr_next = ctr_cur;
        if (actual_takenE) begin
            if (ctr_cur != 2'b11) begin
                ctr_next = ctr_cur + 2'd1;
            end
        end else begin
            if (ctr_cur != 2'b00) begin
                ctr_next = ctr_cur - 2'd1;
            end
        end
    end

    // Training ignores flushE/stallD: a branch sitting in E has resolved regardless
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < PHT_SIZE; i++) begin
                pht[i] <= PHT_INIT;
            end
        end else if (valid_e) begin
            pht[idx_e] <= ctr_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_e      <= 1'b0;
            pred_taken_e <= 1'b0;
            idx_e        <= '0;
            target_e     <= '0;
            pc_plus4_e   <= '0;
        end else if (flushE) begin
            valid_e      <= 1'b0;
            pred_taken_e <= 1'b0;
        end else if (stallD) begin
            valid_e <= 1'b0;
        end else begin
            valid_e      <= branchD;
            pred_taken_e <= pred_takenD;
            idx_e        <= idx_d;
            target_e     <= branch_targetD;
            pc_plus4_e   <= pc_plus4D;
        end
    end

endmodule
